// File: rtl/sine_freq_meter.sv
// sine_freq_meter
//
// Estimates the frequency control word of a phase-accumulator sine generator
// by counting rising midpoint crossings (with hysteresis) over a gate window
// of W = 2^GATE_LOG2 accepted samples. The count is scaled by a constant
// shift into the generator's 24-bit FCW units.
//
// Optional feature macro: SINE_METER_AVG_EN
//   defined   : each report is the truncated mean of this and the previous
//               raw estimate (the first report after reset or re-arm is raw).
//   undefined : each report is the raw estimate.
//
// Handshake: a sample is consumed on every rising clk edge where
// sample_valid is 1; there is no backpressure. est_valid is a one-cycle
// pulse in the cycle after the edge that consumed a window's last sample,
// and fcw_est / signal_present change on that same edge.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   sample_valid   qualifies sample_in
//   sample_in      12-bit offset-binary sample, midpoint 12'h800
//   fcw_est        latest FCW estimate, held between reports
//   est_valid      one-cycle report strobe
//   signal_present last reported window contained at least one crossing
//   state_dbg      FSM state for debug (0 = ARM, 1 = COUNT)

module sine_freq_meter #(
    parameter int GATE_LOG2 = 14,
    parameter int HYST      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample_in,
    output logic [23:0] fcw_est,
    output logic        est_valid,
    output logic        signal_present,
    output logic        state_dbg
);

    localparam int SHIFT = 24 - GATE_LOG2;
    localparam logic [GATE_LOG2-1:0] SCNT_LAST = '1;
    localparam logic [11:0] HI_TH = 12'(2048 + HYST);
    localparam logic [11:0] LO_TH = 12'(2048 - HYST);

    typedef enum logic {
        ARM   = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t               state;
    logic                 hs;
    logic [GATE_LOG2-1:0] scnt;
    logic [GATE_LOG2-1:0] ecnt;

    logic                 rise;
    logic                 win_last;
    logic [GATE_LOG2:0]   e_total;
    logic [24:0]          raw_wide;
    logic [23:0]          raw;
    logic [23:0]          report_val;

    // A crossing is the accepted sample that sets hs from 0; it is judged
    // against the pre-update hs so it lines up with the sample itself.
    assign rise     = sample_valid && !hs && (sample_in >= HI_TH);
    assign win_last = (scnt == SCNT_LAST);
    // The crossing on the final window sample still belongs to this window.
    assign e_total  = {1'b0, ecnt} + (GATE_LOG2 + 1)'(rise);
    assign raw_wide = 25'(e_total) << SHIFT;
    assign raw      = raw_wide[23:0];
    assign state_dbg = (state == COUNT);

`ifdef SINE_METER_AVG_EN
    logic [23:0] prev_raw;
    logic        have_prev;
    logic [24:0] avg_sum;

    assign avg_sum    = {1'b0, raw} + {1'b0, prev_raw};
    assign report_val = have_prev ? avg_sum[24:1] : raw;
`else
    assign report_val = raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ARM;
            hs             <= 1'b0;
            scnt           <= '0;
            ecnt           <= '0;
            fcw_est        <= '0;
            est_valid      <= 1'b0;
            signal_present <= 1'b0;
`ifdef SINE_METER_AVG_EN
            prev_raw       <= '0;
            have_prev      <= 1'b0;
`endif
        end else begin
            est_valid <= 1'b0;
            if (sample_valid) begin
                if (sample_in >= HI_TH) begin
                    hs <= 1'b1;
                end else if (sample_in <= LO_TH) begin
                    hs <= 1'b0;
                end

                case (state)
                    ARM: begin
                        // An arming crossing beats a coincident timeout.
                        if (rise) begin
                            state <= COUNT;
                            scnt  <= '0;
                            ecnt  <= '0;
                        end else if (win_last) begin
                            scnt           <= '0;
                            fcw_est        <= '0;
                            signal_present <= 1'b0;
                            est_valid      <= 1'b1;
`ifdef SINE_METER_AVG_EN
                            prev_raw       <= '0;
                            have_prev      <= 1'b0;
`endif
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    COUNT: begin
                        if (win_last) begin
                            scnt           <= '0;
                            ecnt           <= '0;
                            fcw_est        <= report_val;
                            signal_present <= (e_total != '0);
                            est_valid      <= 1'b1;
`ifdef SINE_METER_AVG_EN
                            prev_raw       <= raw;
                            // Re-arming restarts the averaging history.
                            have_prev      <= (e_total != '0);
`endif
                            if (e_total == '0) begin
                                state <= ARM;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                            ecnt <= ecnt + GATE_LOG2'(rise);
                        end
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sine_freq_meter.sv
// Testbench for sine_freq_meter (GATE_LOG2=8, HYST=64, W=256).
// The generator is modelled as a 24-bit phase accumulator whose MSB picks a
// high or low level, so every accumulator wrap is one rising crossing.
// Expected reports are pushed into exp_q before the stimulus is issued; a
// monitor pops and compares on every est_valid.

module tb_sine_freq_meter;

    localparam int GL = 8;

    logic        clk;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample_in;
    logic [23:0] fcw_est;
    logic        est_valid;
    logic        signal_present;
    logic        state_dbg;

    int          n_tests;
    int          n_fail;
    longint      cyc;
    logic [23:0] phase;
    logic        prev_ev;

    logic [24:0] exp_q[$];   // {signal_present, fcw_est}
    longint      rep_cyc[$];

    sine_freq_meter #(.GATE_LOG2(GL), .HYST(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .fcw_est       (fcw_est),
        .est_valid     (est_valid),
        .signal_present(signal_present),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        sample_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // n accepted samples from the phase model, one every 'gap' clocks.
    task automatic run_tone(input int n, input logic [23:0] fcw, input int gap);
        for (int i = 0; i < n; i++) begin
            sample_in    = phase[23] ? 12'h100 : 12'hF00;
            sample_valid = 1'b1;
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
            phase = phase + fcw;
            repeat (gap - 1) @(posedge clk);
            #1;
        end
    endtask

    // n accepted samples alternating between two fixed levels.
    task automatic run_levels(input int n, input logic [11:0] a, input logic [11:0] b);
        for (int i = 0; i < n; i++) begin
            sample_in    = i[0] ? b : a;
            sample_valid = 1'b1;
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
        end
    endtask

    task automatic expect_rep(input logic [23:0] f, input logic sp);
        exp_q.push_back({sp, f});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Bounded wait for all expected reports to be consumed.
    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (est_valid) begin
            logic [24:0] e;
            rep_cyc.push_back(cyc);
            n_tests++;
            if (prev_ev) begin
                n_fail++;
                $display("FAIL est_valid_pulse: high on two consecutive cycles");
            end
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL report_unexpected: got fcw=%h sp=%b, expected none",
                         fcw_est, signal_present);
            end else begin
                e = exp_q.pop_front();
                if ({signal_present, fcw_est} !== e) begin
                    n_fail++;
                    $display("FAIL report: got fcw=%h sp=%b, expected fcw=%h sp=%b",
                             fcw_est, signal_present, e[23:0], e[24]);
                end
            end
        end
        prev_ev <= est_valid;
    end

    // ---------------- stimulus ----------------
    initial begin
        n_tests      = 0;
        n_fail       = 0;
        cyc          = 0;
        prev_ev      = 1'b0;
        phase        = '0;
        sample_in    = 12'h800;
        sample_valid = 1'b0;
        reset        = 1'b1;

        apply_reset(3);
        check("reset_fcw", fcw_est, 0);
        check("reset_valid", est_valid, 0);
        check("reset_sp", signal_present, 0);
        check("reset_state", state_dbg, 0);

        // Locked tone then a step at a window boundary. Arming crossing is
        // sample 0; with 0x040000 crossings recur every 64 samples, so the
        // window 1..256 holds 4 (the last coincides with the window end).
        phase = '0;
        expect_rep(24'h040000, 1'b1);
`ifdef SINE_METER_AVG_EN
        expect_rep(24'h030000, 1'b1);
`else
        expect_rep(24'h020000, 1'b1);
`endif
        expect_rep(24'h020000, 1'b1);
        run_tone(256, 24'h040000, 1);
        run_tone(513, 24'h020000, 1);
        drain("step");

        // Signal vanishes: one window ends with no crossings (back to ARM),
        // then a timeout report 256 samples later.
`ifdef SINE_METER_AVG_EN
        expect_rep(24'h010000, 1'b0);
`else
        expect_rep(24'h000000, 1'b0);
`endif
        expect_rep(24'h000000, 1'b0);
        run_levels(512, 12'h800, 12'h800);
        drain("nosig");
        check("nosig_state", state_dbg, 0);

        // Noise inside the hysteresis band never arms.
        expect_rep(24'h000000, 1'b0);
        run_levels(256, 12'h7C8, 12'h838);
        drain("noise");

        // Reset halfway through the second window.
        apply_reset(2);
        phase = '0;
        expect_rep(24'h040000, 1'b1);
        run_tone(257 + 128, 24'h040000, 1);
        drain("pre_reset");
        check("pre_reset_sp", signal_present, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_fcw", fcw_est, 0);
        check("midreset_sp", signal_present, 0);
        check("midreset_state", state_dbg, 0);
        reset = 1'b0;
        phase = '0;
        expect_rep(24'h040000, 1'b1);
        run_tone(257, 24'h040000, 1);
        drain("post_reset");

        // Strobe every 3 clocks: reports 3*W clocks apart.
        apply_reset(2);
        phase = '0;
        rep_cyc.delete();
        expect_rep(24'h020000, 1'b1);
        expect_rep(24'h020000, 1'b1);
        run_tone(513, 24'h020000, 3);
        drain("gapped");
        if (rep_cyc.size() >= 2) begin
            check("gapped_period", 32'(rep_cyc[1] - rep_cyc[0]), 768);
        end else begin
            check("gapped_report_count", rep_cyc.size(), 2);
        end

        // Low tone: one crossing per window.
        apply_reset(2);
        phase = '0;
        expect_rep(24'h010000, 1'b1);
        run_tone(257, 24'h010000, 1);
        drain("low");

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
